// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio definitions: default parameter values for the audio cores and
// the stereo sample pair carried between them.
//
// Samples are stored left-justified in fields of AUDIO_MAX_SAMPLE_WIDTH bits,
// so one packed struct serves every configured sample width. The unused low
// bits are zero, and a core can shift the MSB out first without any indexing.
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH_DEFAULT = 16;
    localparam int AUDIO_SLOT_WIDTH_DEFAULT   = 32;
    localparam int AUDIO_BCLK_DIV_DEFAULT     = 4;
    localparam int AUDIO_HOLD_DEPTH_DEFAULT   = 1;

    // Widest PCM sample a stereo_sample_t field can hold.
    localparam int AUDIO_MAX_SAMPLE_WIDTH     = 32;

    typedef struct packed {
        logic [AUDIO_MAX_SAMPLE_WIDTH-1:0] left;
        logic [AUDIO_MAX_SAMPLE_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage : audio_pkg

// File: rtl/i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// i2s_audio_tx
// I2S master transmitter. The module divides clk down to the bit clock, frames
// left/right slots on the word select, and shifts signed PCM out MSB-first with
// the standard one-bit delay after each word-select edge. A small holding
// buffer decouples the sample producer from the frame timing.
//
// Parameters
//   SAMPLE_WIDTH : PCM bits per channel (1 .. SLOT_WIDTH-1)
//   SLOT_WIDTH   : bit clocks per channel slot
//   BCLK_DIV     : clk cycles per bit clock (even, >= 2)
//   HOLD_DEPTH   : stereo pairs the holding buffer can keep (1 or 2)
//
// Ports
//   clk          : master clock, the only clock in the module
//   reset_n      : asynchronous active-low reset
//   sample_l/_r  : left/right PCM sample offered by the producer
//   sample_valid : producer offers a pair this cycle
//   sample_ready : a holding entry is free (registered)
//   mono         : right slot repeats the left sample (latched per frame)
//   mute         : force zero data (latched per frame)
//   audio_sclk   : I2S bit clock
//   audio_lrck   : I2S word select, 0 = left slot, 1 = right slot
//   audio_dac    : I2S serial data, changes on sclk falling edges
//   underrun     : one-cycle pulse in the last cycle of a frame when no new
//                  pair is waiting; the previous pair is then repeated
// -----------------------------------------------------------------------------
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH_DEFAULT,
    parameter int SLOT_WIDTH   = AUDIO_SLOT_WIDTH_DEFAULT,
    parameter int BCLK_DIV     = AUDIO_BCLK_DIV_DEFAULT,
    parameter int HOLD_DEPTH   = AUDIO_HOLD_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    mono,
    input  logic                    mute,
    output logic                    audio_sclk,
    output logic                    audio_lrck,
    output logic                    audio_dac,
    output logic                    underrun
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > SLOT_WIDTH - 1) begin : g_bad_sample_width
        $error("i2s_audio_tx: SAMPLE_WIDTH (%0d) must be 1..SLOT_WIDTH-1 (%0d)",
               SAMPLE_WIDTH, SLOT_WIDTH - 1);
    end
    if (SAMPLE_WIDTH > AUDIO_MAX_SAMPLE_WIDTH) begin : g_bad_sample_max
        $error("i2s_audio_tx: SAMPLE_WIDTH (%0d) exceeds AUDIO_MAX_SAMPLE_WIDTH (%0d)",
               SAMPLE_WIDTH, AUDIO_MAX_SAMPLE_WIDTH);
    end
    if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_bclk_div
        $error("i2s_audio_tx: BCLK_DIV (%0d) must be even and >= 2", BCLK_DIV);
    end
    if (HOLD_DEPTH != 1 && HOLD_DEPTH != 2) begin : g_bad_hold_depth
        $error("i2s_audio_tx: HOLD_DEPTH (%0d) must be 1 or 2", HOLD_DEPTH);
    end

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = (SLOT_WIDTH > 2) ? $clog2(SLOT_WIDTH) : 1;
    localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
    localparam int PAD_W = AUDIO_MAX_SAMPLE_WIDTH - SAMPLE_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLD_FULL = CNT_W'(HOLD_DEPTH);

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_next;
    logic             lrck_q;
    logic             lrck_next;
    logic             sclk_q;
    logic             dac_q;

    logic             div_wrap;    // last clk of a bit period (sclk falls next)
    logic             slot_end;    // last clk of a slot
    logic             frame_end;   // last clk of the right slot: transfer cycle

    stereo_sample_t   hold_mem [HOLD_DEPTH];
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    logic [CNT_W-1:0] wr_idx;
    logic             hold_empty;
    logic             ready_q;
    logic             accept;
    logic             pop;

    stereo_sample_t   pair_in;
    stereo_sample_t   active_q;
    stereo_sample_t   active_next;
    logic             mono_q;
    logic             mono_next;
    logic             mute_q;
    logic             mute_next;

    logic [AUDIO_MAX_SAMPLE_WIDTH-1:0] shreg_q;
    logic [AUDIO_MAX_SAMPLE_WIDTH-1:0] slot_word;

    // -------------------------------------------------------------------------
    // Bit-clock and slot timing
    // -------------------------------------------------------------------------
    // NOTE: every variable in an always_comb gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        div_wrap  = (div_cnt == DIV_LAST);
        slot_end  = div_wrap && (bit_cnt == BIT_LAST);
        frame_end = slot_end && lrck_q;

        div_next  = div_wrap ? '0 : div_cnt + 1'b1;

        bit_next  = bit_cnt;
        if (div_wrap) begin
            bit_next = slot_end ? '0 : bit_cnt + 1'b1;
        end

        lrck_next = slot_end ? ~lrck_q : lrck_q;
    end

    // -------------------------------------------------------------------------
    // Holding buffer control
    // -------------------------------------------------------------------------
    // Incoming samples are left-justified so the MSB sits at the top of the
    // shared field width.
    always_comb begin
        pair_in.left  = AUDIO_MAX_SAMPLE_WIDTH'(sample_l) << PAD_W;
        pair_in.right = AUDIO_MAX_SAMPLE_WIDTH'(sample_r) << PAD_W;
    end

    always_comb begin
        hold_empty = (hold_cnt == '0);
        accept     = sample_valid && ready_q;
        pop        = frame_end && !hold_empty;

        hold_cnt_next = hold_cnt;
        case ({accept, pop})
            2'b10:   hold_cnt_next = hold_cnt + 1'b1;
            2'b01:   hold_cnt_next = hold_cnt - 1'b1;
            default: hold_cnt_next = hold_cnt;   // idle, or push and pop together
        endcase

        // A push that coincides with a pop lands one slot lower, because the
        // entries shift down in the same cycle.
        wr_idx = pop ? hold_cnt - 1'b1 : hold_cnt;
    end

    // When the buffer is empty at the transfer point, the old pair is kept.
    assign underrun = frame_end && hold_empty;

    // NOTE: the holding entries have no reset. hold_cnt alone says which
    // entries are valid, so the data storage needs no reset network.
    always_ff @(posedge clk) begin
        for (int i = 0; i < HOLD_DEPTH - 1; i++) begin
            if (pop) begin
                hold_mem[i] <= hold_mem[i + 1];
            end
        end
        // The write comes after the shift so that it wins when both target the
        // same entry.
        for (int i = 0; i < HOLD_DEPTH; i++) begin
            if (accept && (CNT_W'(i) == wr_idx)) begin
                hold_mem[i] <= pair_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame-level selection: active pair, mono/mute latched at frame start
    // -------------------------------------------------------------------------
    always_comb begin
        active_next = pop       ? hold_mem[0] : active_q;
        mono_next   = frame_end ? mono        : mono_q;
        mute_next   = frame_end ? mute        : mute_q;

        // This is the word for the slot that starts after the current edge.
        // It is used only when slot_end loads the shift register.
        slot_word = active_next.left;
        if (mute_next) begin
            slot_word = '0;
        end else if (lrck_next && !mono_next) begin
            slot_word = active_next.right;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            lrck_q   <= 1'b0;
            sclk_q   <= 1'b0;
            dac_q    <= 1'b0;
            shreg_q  <= '0;
            hold_cnt <= '0;
            ready_q  <= 1'b0;
            active_q <= '0;
            mono_q   <= 1'b0;
            mute_q   <= 1'b0;
        end else begin
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            lrck_q   <= lrck_next;
            sclk_q   <= (div_next >= DIV_HALF);
            hold_cnt <= hold_cnt_next;
            ready_q  <= (hold_cnt_next != HOLD_FULL);
            active_q <= active_next;
            mono_q   <= mono_next;
            mute_q   <= mute_next;

            // Bit 0 of each slot is the one-bit I2S delay, so it is always 0.
            // The sample MSB follows on the next bit. Once the sample has been
            // shifted out, only zeros remain, which pads the rest of the slot.
            if (slot_end) begin
                shreg_q <= slot_word;
                dac_q   <= 1'b0;
            end else if (div_wrap) begin
                dac_q   <= shreg_q[AUDIO_MAX_SAMPLE_WIDTH-1];
                shreg_q <= shreg_q << 1;
            end
        end
    end

    assign audio_sclk   = sclk_q;
    assign audio_lrck   = lrck_q;
    assign audio_dac    = dac_q;
    assign sample_ready = ready_q;

endmodule : i2s_audio_tx

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, meaning signed PCM bits per channel.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32, meaning bit clocks per channel slot.
REQ-003 SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per bit clock; even, >=2.
REQ-004 SHALL have parameter HOLD_DEPTH, default 1 (1 or 2), meaning stereo sample holding entries.
REQ-005 clk  in  1  serial master clock (12.288 MHz nominal); one clock only.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 sample_l, sample_r  in  SAMPLE_WIDTH each  left and right PCM samples.
REQ-008 sample_valid  in  1  sample pair offered; sample_ready  out  1  holding entry free.
REQ-009 mono  in  1  right slot repeats left sample; mute  in  1  force zero data.
REQ-010 audio_sclk, audio_lrck, audio_dac  out  1 each  I2S bit clock, word select, serial data.
REQ-011 underrun  out  1  one-cycle pulse on frame start with no fresh sample.

Function
REQ-012 SHALL count div_cnt 0..BCLK_DIV-1 each clk; audio_sclk = 1 when div_cnt >= BCLK_DIV/2.
REQ-013 SHALL advance bit_cnt 0..SLOT_WIDTH-1 when div_cnt wraps to 0 (sclk falling edge); audio_dac and audio_lrck change only on that edge.
REQ-014 SHALL toggle audio_lrck when bit_cnt wraps to 0; lrck=0 is left slot, lrck=1 right slot; frame = left+right.
REQ-015 SHALL output, per slot, bit 0 = 0, bits 1..SAMPLE_WIDTH = sample MSB..LSB, remaining bits 0 (standard one-bit-delay I2S).
REQ-016 SHALL accept a pair when sample_valid && sample_ready; sample_ready = holding not full, registered, no combinational path from sample_valid.
REQ-017 SHALL transfer the oldest holding entry into the active pair on the clk cycle where div_cnt=BCLK_DIV-1, bit_cnt=SLOT_WIDTH-1, lrck=1 (last cycle of frame).
REQ-018 SHALL, if holding empty at transfer, keep the previous active pair and assert underrun for that one cycle.
REQ-019 SHALL, on accept coinciding with transfer when empty, store the new pair in holding (underrun still pulses); if not empty, accept and transfer in the same cycle keep occupancy constant.
REQ-020 SHALL sample mono and mute at frame start (transfer cycle) and hold them for the whole frame.
REQ-021 SHALL with mute emit zero data while still consuming holding entries at frame rate.
REQ-022 SHALL reject SAMPLE_WIDTH > SLOT_WIDTH-1 or odd BCLK_DIV with an elaboration-time error.
REQ-023 Frame rate SHALL equal f_clk/(2*SLOT_WIDTH*BCLK_DIV): 48 kHz at defaults.

Reset
REQ-024 On reset_n low: div_cnt, bit_cnt = 0; audio_sclk, audio_dac, underrun = 0; audio_lrck = 0; active pair zero; holding empty; sample_ready = 0 during reset, 1 on the first clk after release.
REQ-025 Reset asserted mid-frame SHALL abort immediately; first frame after release starts at left slot bit 0 with zero data.

Structure
REQ-026 Shared package audio_pkg SHALL hold default parameter constants and the stereo sample struct (left, right); no core-specific types.
REQ-027 SHALL be flat; the holding buffer is inline; no sub-module.

Verification
REQ-028 Defaults, push L=16'h8001, R=16'h7FFE once -> second frame left slot dac bits 1..16 = 1000000000000001, right = 0111111111111110, others 0.
REQ-029 Free-run 1,000,000 clk -> sclk period 4 clk, lrck period 256 clk, toggles aligned with sclk falling edge.
REQ-030 No samples after one push -> underrun pulses once per 256 clk from frame 3, dac repeats last pair.
REQ-031 mono=1, L=16'h1234, R=16'hFFFF -> both slots carry 0x1234; mute=1 -> dac constant 0, sample_ready still cycles.
REQ-032 HOLD_DEPTH=2, push 3 pairs back-to-back -> ready drops after 2nd accept, rises 1 clk after next transfer; order preserved.
REQ-033 reset_n low at bit_cnt=10 of right slot -> all outputs 0 asynchronously; after release lrck=0, bit_cnt restarts at 0.
